// File: rtl/alu_shift_sequencer.sv
// rtl/alu_shift_sequencer.sv - multi-pass sequencer driving a one-bit-per-pass ALU
module alu_shift_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int OP_W    = 5
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift and rotate ops occupy the contiguous code range shr..shra.
    localparam logic [OP_W-1:0]    OP_FIRST_SHIFT = OP_W'(5);
    localparam logic [OP_W-1:0]    OP_LAST_SHIFT  = OP_W'(9);
    localparam logic [SHAMT_W-1:0] ONE_PASS       = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] ZERO_PASS      = '0;

    state_t              state;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [OP_W-1:0]     op_reg;
    logic [SHAMT_W-1:0]  count;
    logic                is_shift;
    logic [SHAMT_W-1:0]  shamt;

    // The ALU only ever sees registered operands and op.
    assign alu_a  = a_reg;
    assign alu_b  = b_reg;
    assign alu_op = op_reg;

    // Decode of the incoming request: does it iterate, and by how much.
    always_comb begin
        is_shift = (op >= OP_FIRST_SHIFT) && (op <= OP_LAST_SHIFT);
        shamt    = b[SHAMT_W-1:0];
    end

    // Sequencer FSM with registered done/busy; clear abandons any in-flight op.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            count  <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op;
                        busy   <= 1'b1;
                        if (is_shift) begin
                            count <= shamt;
                            if (shamt == ZERO_PASS) begin
                                // Shift by zero never touches the ALU.
                                result <= a;
                                state  <= DONE;
                                done   <= 1'b1;
                            end else begin
                                state <= ITER;
                            end
                        end else begin
                            // Logic/arith and undefined ops are a single pass.
                            count <= ONE_PASS;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    a_reg <= alu_c;
                    count <= count - ONE_PASS;
                    if (count == ONE_PASS) begin
                        result <= alu_c;
                        state  <= DONE;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb/tb_alu_shift_sequencer.sv - scoreboard bench for alu_shift_sequencer
module tb_alu_shift_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_c;
    logic [31:0] result;
    logic        done;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_shift_sequencer #(.DATA_W(32), .SHAMT_W(5), .OP_W(5)) dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_c  (alu_c),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Reference ALU: shift/rotate ops move one bit per pass, default is AND.
    always_comb begin
        case (alu_op)
            5'd0:    alu_c = alu_a | alu_b;
            5'd1:    alu_c = alu_a & alu_b;
            5'd2:    alu_c = alu_a + alu_b;
            5'd3:    alu_c = alu_a - alu_b;
            5'd4:    alu_c = -alu_a;
            5'd5:    alu_c = alu_a >> 1;
            5'd6:    alu_c = alu_a << 1;
            5'd7:    alu_c = {alu_a[0], alu_a[31:1]};
            5'd8:    alu_c = {alu_a[30:0], alu_a[31]};
            5'd9:    alu_c = {alu_a[31], alu_a[31:1]};
            default: alu_c = alu_a & alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with result 0x%08h at edge %0d, expected none", result, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", edge_cnt, e.at);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] res, input int lat, input bit expect_done);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        if (expect_done) sb.push_back('{res: res, at: edge_cnt + lat});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) return;
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: busy still %0d after 100 cycles, expected 0", busy);
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_op", {27'b0, alu_op}, 32'd0);
        clear = 1'b0;
        tick();

        // Single-pass AND
        issue(5'd1, 32'hF0F0F0F0, 32'h0FF0FF00, 32'h00F0F000, 2, 1'b1);
        tick();
        start = 1'b0;
        check("and_alu_op_c1", {27'b0, alu_op}, 32'd1);
        check("and_busy_c1", {31'b0, busy}, 32'd1);
        tick();
        check("and_busy_c2", {31'b0, busy}, 32'd1);
        wait_idle();

        // Shift left by 3, watching the ALU operand step
        issue(5'd6, 32'h00000001, 32'd3, 32'h00000008, 4, 1'b1);
        tick();
        start = 1'b0;
        check("shl_alu_a_c1", alu_a, 32'h1);
        tick();
        check("shl_alu_a_c2", alu_a, 32'h2);
        tick();
        check("shl_alu_a_c3", alu_a, 32'h4);
        wait_idle();

        // Rotate right by 4
        issue(5'd7, 32'h0000000F, 32'd4, 32'hF0000000, 5, 1'b1);
        tick();
        start = 1'b0;
        wait_idle();

        // Arithmetic shift right by the maximum amount
        issue(5'd9, 32'h80000000, 32'd31, 32'hFFFFFFFF, 32, 1'b1);
        tick();
        start = 1'b0;
        wait_idle();

        // Shift by zero: b low bits are 0
        issue(5'd5, 32'h12345678, 32'h00000020, 32'h12345678, 1, 1'b1);
        tick();
        start = 1'b0;
        check("shr0_busy_c1", {31'b0, busy}, 32'd1);
        wait_idle();

        // Rotate left by 10, ignored second start, then abort via clear
        issue(5'd8, 32'h00000001, 32'd10, 32'h0, 0, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        op    = 5'd2;
        a     = 32'hFFFF0000;
        b     = 32'd3;
        tick();
        start = 1'b0;
        check("rol_alu_a_c4", alu_a, 32'h00000008);
        tick();
        check("rol_alu_a_c5", alu_a, 32'h00000010);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        repeat (40) tick();
        check("abort_stays_idle", {31'b0, busy}, 32'd0);

        // Back-to-back add then sub
        issue(5'd2, 32'd2, 32'd3, 32'd5, 2, 1'b1);
        tick();
        start = 1'b0;
        tick();
        tick();
        issue(5'd3, 32'd5, 32'd7, 32'hFFFFFFFE, 2, 1'b1);
        tick();
        start = 1'b0;
        wait_idle();

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
Multi-cycle controller sitting between the control unit and the 32-bit ALU. The ALU's shift and rotate ops (5-9) move one bit per pass. This block accepts an op plus operands, then drives the ALU's A/B/op inputs and feeds the ALU result back into A once per clock, giving shift/rotate by B[4:0] positions. Ops 0-4 (or, and, add, sub, negate) and undefined ops run as a single pass, so the control unit sees one uniform start/done interface.

Parameters:
DATA_W, 32, operand/result width; must match the ALU.
SHAMT_W, 5, width of shift-amount field taken from b[SHAMT_W-1:0].
OP_W, 5, ALU op code width.

Ports:
clock  in  1  rising-edge clock
clear  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  OP_W  ALU op code (0 or, 1 and, 2 add, 3 sub, 4 neg, 5 shr, 6 shl, 7 ror, 8 rol, 9 shra)
a  in  DATA_W  operand A
b  in  DATA_W  operand B; low SHAMT_W bits are the shift amount for ops 5-9
alu_a  out  DATA_W  to ALU A (registered)
alu_b  out  DATA_W  to ALU B (registered)
alu_op  out  OP_W  to ALU op (registered)
alu_c  in  DATA_W  ALU combinational result
result  out  DATA_W  final result; held until the next accepted start
done  out  1  one-cycle pulse, result valid
busy  out  1  high while not IDLE

Behaviour:
- Reset (clear=1 at an edge, takes priority over everything, including mid-operation): state=IDLE; a_reg, b_reg, op_reg, count, result = 0; done=0; busy=0. Any in-flight op is abandoned and produces no done.
- alu_a=a_reg, alu_b=b_reg, alu_op=op_reg at all times. The ALU sees only registered values.
- States: IDLE, ITER, DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE:
  - start=1 latches a_reg<=a, b_reg<=b, op_reg<=op.
  - For op 5-9, count<=b[SHAMT_W-1:0]; for any other op (including 10-31), count<=1.
  - If the loaded count is 0 (shift by 0), then result<=a and next state is DONE; otherwise next state is ITER.
  - start=0: stay in IDLE.
- ITER: each cycle a_reg<=alu_c and count<=count-1.
  - When count==1: result<=alu_c and next state is DONE.
  - Otherwise stay in ITER.
  - Ops 0-4 and undefined ops make exactly one pass; undefined ops yield the ALU default (AND).
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start while busy (ITER or DONE) is ignored and is not queued. A new op can be accepted in the cycle after DONE, so back-to-back throughput is one op every N+2 cycles.
- Latency, with start sampled at edge 0:
  - Shift by N≥1: ITER occupies cycles 1..N, done high in cycle N+1.
  - Single-pass op: done in cycle 2.
  - Shift by 0: done in cycle 1.
- Max shift amount 31 → 31 ITER cycles. count never wraps: it is only decremented while ≥1.
- result and alu_* hold their values in IDLE. Inputs a/b/op may change freely after the start edge.

Test Plan:
- Reset, then start with op=1, a=0xF0F0F0F0, b=0x0FF0FF00 → ALU sees op 1 in cycle 1; done in cycle 2; result=0x00F0F000; busy high in cycles 1-2.
- op=6 (shl), a=0x00000001, b=3 → alu_a steps 1,2,4 in cycles 1-3; done in cycle 4 with result=0x00000008; no done before cycle 4.
- op=7 (ror), a=0x0000000F, b=4 → result=0xF0000000, done in cycle 5. Then op=9 (shra), a=0x80000000, b=31 → result=0xFFFFFFFF, done in cycle 32.
- op=5, a=0x12345678, b=0x20 (low bits 0) → no ITER; done in cycle 1; result=0x12345678.
- Start op=8, b=10; pulse start again at cycle 3 with different a → second request ignored, result is for the first op only. Assert clear at cycle 5 → cycle 6: busy=0, done=0, result=0, and no done ever appears for the aborted op.
- Back-to-back: an add (2+3) finishes with done in cycle 2; start sampled at edge 3 for a sub (5-7) → results 5 then 0xFFFFFFFE, with two separate single-cycle done pulses.
